// File: rtl/difetto_bsr_driver_if.sv
// Host/chain signal bundle for difetto_bsr_driver.
// The slave modport is the driver's view; master is the host/chain side.
interface difetto_bsr_driver_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [WORD_W-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [WORD_W-1:0] rdata;
    logic              rdata_last;
    logic              scan_en;
    logic              scan_si;
    logic              scan_so;
    logic              capture_en;
    logic              update_en;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, wdata_valid, wdata, rdata_ready, scan_so,
        output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last,
        output scan_en, scan_si, capture_en, update_en, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_len, wdata_valid, wdata, rdata_ready, scan_so,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last,
        input  scan_en, scan_si, capture_en, update_en, busy
    );
endinterface

// File: rtl/difetto_bsr_driver.sv
// Boundary-scan chain driver: CAPTURE/UPDATE strobes and SHIFT commands that
// serialise host words onto the chain and collect the chain output as read words.
module difetto_bsr_driver #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    difetto_bsr_driver_if.slave bus
);
    localparam int unsigned CntW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {StIdle, StCap, StUpd, StLoad, StShift, StEmit} state_e;

    state_e            state_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] rd_q;
    logic [WORD_W-1:0] shift_nxt;
    logic [LEN_W-1:0]  rem_q;
    logic [CntW-1:0]   bit_idx_q;
    logic [CntW-1:0]   word_bits_q;
    logic              cmd_ready_q;
    logic              wdata_ready_q;
    logic              rdata_valid_q;
    logic              rdata_last_q;
    logic              scan_en_q;
    logic              scan_si_q;
    logic              capture_en_q;
    logic              update_en_q;
    logic              busy_q;
    logic              bit_last;

    assign shift_nxt = shift_q >> 1;
    assign bit_last  = (bit_idx_q + CntW'(1)) == word_bits_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            rd_q          <= '0;
            rem_q         <= '0;
            bit_idx_q     <= '0;
            word_bits_q   <= '0;
            cmd_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            scan_en_q     <= 1'b0;
            scan_si_q     <= 1'b0;
            capture_en_q  <= 1'b0;
            update_en_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        rem_q <= bus.cmd_len;
                        case (bus.cmd_op)
                            2'b00: begin
                                state_q      <= StCap;
                                capture_en_q <= 1'b1;
                                cmd_ready_q  <= 1'b0;
                                busy_q       <= 1'b1;
                            end
                            2'b01: begin
                                state_q     <= StUpd;
                                update_en_q <= 1'b1;
                                cmd_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                            2'b10: begin
                                // Zero-length SHIFT is a no-op and leaves us in idle.
                                if (bus.cmd_len != '0) begin
                                    state_q       <= StLoad;
                                    wdata_ready_q <= 1'b1;
                                    cmd_ready_q   <= 1'b0;
                                    busy_q        <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StCap, StUpd: begin
                    state_q      <= StIdle;
                    capture_en_q <= 1'b0;
                    update_en_q  <= 1'b0;
                    cmd_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                end
                StLoad: begin
                    if (bus.wdata_valid && wdata_ready_q) begin
                        state_q       <= StShift;
                        shift_q       <= bus.wdata;
                        rd_q          <= '0;
                        bit_idx_q     <= '0;
                        word_bits_q   <= (32'(rem_q) >= WORD_W) ? CntW'(WORD_W) : CntW'(rem_q);
                        wdata_ready_q <= 1'b0;
                        scan_en_q     <= 1'b1;
                        scan_si_q     <= bus.wdata[0];
                    end
                end
                StShift: begin
                    rd_q      <= rd_q | (WORD_W'(bus.scan_so) << bit_idx_q);
                    shift_q   <= shift_nxt;
                    bit_idx_q <= bit_idx_q + CntW'(1);
                    if (rem_q != '0) begin
                        rem_q <= rem_q - LEN_W'(1);
                    end
                    if (bit_last) begin
                        state_q       <= StEmit;
                        scan_en_q     <= 1'b0;
                        scan_si_q     <= 1'b0;
                        rdata_valid_q <= 1'b1;
                        rdata_last_q  <= (rem_q == LEN_W'(1));
                    end else begin
                        scan_si_q <= shift_nxt[0];
                    end
                end
                StEmit: begin
                    if (bus.rdata_ready) begin
                        rdata_valid_q <= 1'b0;
                        rdata_last_q  <= 1'b0;
                        if (rem_q != '0) begin
                            state_q       <= StLoad;
                            wdata_ready_q <= 1'b1;
                        end else begin
                            state_q     <= StIdle;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.wdata_ready = wdata_ready_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rd_q;
    assign bus.rdata_last  = rdata_last_q;
    assign bus.scan_en     = scan_en_q;
    assign bus.scan_si     = scan_si_q;
    assign bus.capture_en  = capture_en_q;
    assign bus.update_en   = update_en_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_difetto_bsr_driver.sv
// Self-checking bench for difetto_bsr_driver with WORD_W=8: command table,
// directed shift/backpressure/abort sequences and randomized shifts vs a bit-list model.
module tb_difetto_bsr_driver;
    localparam int unsigned WW = 8;
    localparam int unsigned LW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    difetto_bsr_driver_if #(.WORD_W(WW), .LEN_W(LW)) bus ();

    difetto_bsr_driver #(.WORD_W(WW), .LEN_W(LW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Chain-tail model: constant, 3-bit delay line fed from SCAN_SI, or random.
    int       so_mode = 0;
    logic     so_const = 1'b0;
    logic     so_rand = 1'b0;
    logic     dly_load = 1'b0;
    logic [2:0] dly = 3'b000;
    assign bus.scan_so = (so_mode == 0) ? so_const : (so_mode == 1) ? dly[0] : so_rand;

    always @(posedge clk) begin
        if (dly_load) dly <= 3'b101;
        else if (bus.scan_en) dly <= {bus.scan_si, dly[2:1]};
        so_rand <= 1'($urandom);
    end

    // Passive monitor: only appends/increments, tasks work with deltas.
    logic si_q[$];
    logic so_q[$];
    int cnt_scan = 0, cnt_cap = 0, cnt_upd = 0, cnt_wrdy = 0, cnt_rv = 0, cnt_si_bad = 0;
    always @(negedge clk) begin
        if (bus.scan_en) begin
            si_q.push_back(bus.scan_si);
            so_q.push_back(bus.scan_so);
            cnt_scan++;
        end
        if (bus.capture_en) cnt_cap++;
        if (bus.update_en) cnt_upd++;
        if (bus.wdata_ready) cnt_wrdy++;
        if (bus.rdata_valid) cnt_rv++;
        if (!bus.scan_en && bus.scan_si) cnt_si_bad++;
    end

    logic [7:0] wq[$];
    logic [7:0] rq[$];
    logic       lq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {bus.cmd_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata, bus.rdata_last,
                bus.scan_en, bus.scan_si, bus.capture_en, bus.update_en, bus.busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] len);
        int c = 0;
        while (!bus.cmd_ready && c < 10) begin
            step();
            c++;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_len   = 16'($urandom);
    endtask

    // Runs one SHIFT of n bits using wq, holding each read word for bp cycles.
    task automatic run_shift(input int n, input int bp);
        int nw, nb, c;
        logic [11:0] hold;
        rq.delete();
        lq.delete();
        send_cmd(2'b10, 16'(n));
        nw = (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            nb = (n - 8 * w > 8) ? 8 : n - 8 * w;
            c = 0;
            while (!bus.wdata_ready && c < 10) begin
                step();
                c++;
            end
            check("wdata_ready_wait", bus.wdata_ready, 1);
            if (!bus.wdata_ready) return;
            bus.wdata_valid = 1'b1;
            bus.wdata       = wq[w];
            step();
            bus.wdata_valid = 1'b0;
            bus.wdata       = 8'($urandom);
            check("first_scan_en", bus.scan_en, 1);
            c = 0;
            while (!bus.rdata_valid && c < 40) begin
                step();
                c++;
            end
            check("rdata_latency", c, nb);
            if (!bus.rdata_valid) return;
            hold = {bus.rdata_valid, bus.rdata, bus.rdata_last, bus.scan_en, bus.wdata_ready};
            for (int k = 0; k < bp; k++) begin
                step();
                check("bp_stable", {bus.rdata_valid, bus.rdata, bus.rdata_last, bus.scan_en,
                                    bus.wdata_ready}, hold);
            end
            rq.push_back(bus.rdata);
            lq.push_back(bus.rdata_last);
            bus.rdata_ready = 1'b1;
            step();
            bus.rdata_ready = 1'b0;
        end
        c = 0;
        while (!bus.cmd_ready && c < 10) begin
            step();
            c++;
        end
        check("cmd_ready_after_shift", {bus.cmd_ready, bus.busy}, 2'b10);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] len;
        int          cap;
        int          upd;
        int          gap;
    } cmd_vec_t;

    cmd_vec_t vt[6];
    logic     exp_si[8];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_scan, b_cap, b_upd, b_wrdy, b_rv, sbase, c, n, nw, nb, bp;
        logic [7:0] exp;

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_len = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata = '0;
        bus.rdata_ready = 1'b0;

        // Reset and idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", 32'(outs()), 0);
        rst_n = 1'b1;
        #1;
        check("cmd_ready_low_before_edge", bus.cmd_ready, 0);
        step();
        check("cmd_ready_after_reset", bus.cmd_ready, 1);
        check("busy_after_reset", bus.busy, 0);

        // Table of short commands: strobe counts and cycles with CMD_READY low.
        vt[0] = '{op: 2'b00, len: 16'd0,   cap: 1, upd: 0, gap: 1};
        vt[1] = '{op: 2'b01, len: 16'd5,   cap: 0, upd: 1, gap: 1};
        vt[2] = '{op: 2'b10, len: 16'd0,   cap: 0, upd: 0, gap: 0};
        vt[3] = '{op: 2'b11, len: 16'd7,   cap: 0, upd: 0, gap: 0};
        vt[4] = '{op: 2'b00, len: 16'd100, cap: 1, upd: 0, gap: 1};
        vt[5] = '{op: 2'b11, len: 16'd0,   cap: 0, upd: 0, gap: 0};
        for (int i = 0; i < 6; i++) begin
            b_scan = cnt_scan; b_cap = cnt_cap; b_upd = cnt_upd; b_wrdy = cnt_wrdy;
            send_cmd(vt[i].op, vt[i].len);
            c = 0;
            while (!bus.cmd_ready && c < 10) begin
                step();
                c++;
            end
            check("cmd_ready_gap", c, vt[i].gap);
            step();
            check("capture_strobes", cnt_cap - b_cap, vt[i].cap);
            check("update_strobes", cnt_upd - b_upd, vt[i].upd);
            check("no_scan_en", cnt_scan - b_scan, 0);
            check("no_wdata_ready", cnt_wrdy - b_wrdy, 0);
        end

        // CAPTURE then UPDATE back-to-back, cycle by cycle.
        b_scan = cnt_scan;
        send_cmd(2'b00, 16'd0);
        check("cap_cycle", {bus.capture_en, bus.update_en, bus.cmd_ready, bus.busy}, 4'b1001);
        step();
        check("cap_done", {bus.capture_en, bus.cmd_ready, bus.busy}, 3'b010);
        send_cmd(2'b01, 16'd0);
        check("upd_cycle", {bus.capture_en, bus.update_en, bus.cmd_ready, bus.busy}, 4'b0101);
        step();
        check("upd_done", {bus.update_en, bus.cmd_ready}, 2'b01);
        check("capupd_no_scan_en", cnt_scan - b_scan, 0);

        // SHIFT 8 bits of 0xA5 through a 3-bit delay preloaded with 0b101.
        exp_si = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        so_mode = 1;
        dly_load = 1'b1;
        step();
        dly_load = 1'b0;
        wq.delete();
        wq.push_back(8'hA5);
        b_scan = cnt_scan;
        sbase = si_q.size();
        run_shift(8, 0);
        check("a5_scan_cycles", cnt_scan - b_scan, 8);
        for (int i = 0; i < 8; i++) begin
            if (sbase + i < si_q.size()) check("a5_si_bit", si_q[sbase + i], exp_si[i]);
        end
        check("a5_words", rq.size(), 1);
        if (rq.size() == 1) begin
            check("a5_rdata", rq[0], 8'h2D);
            check("a5_last", lq[0], 1);
        end

        // SHIFT 12 bits with SCAN_SO=1 and 5 cycles of read backpressure per word.
        so_mode = 0;
        so_const = 1'b1;
        wq.delete();
        wq.push_back(8'hFF);
        wq.push_back(8'h0F);
        b_scan = cnt_scan;
        run_shift(12, 5);
        check("n12_scan_cycles", cnt_scan - b_scan, 12);
        check("n12_words", rq.size(), 2);
        if (rq.size() == 2) begin
            check("n12_rdata0", rq[0], 8'hFF);
            check("n12_last0", lq[0], 0);
            check("n12_rdata1", rq[1], 8'h0F);
            check("n12_last1", lq[1], 1);
        end

        // Reset pulsed after three shifted bits of an 8-bit SHIFT.
        so_mode = 2;
        b_rv = cnt_rv;
        send_cmd(2'b10, 16'd8);
        bus.wdata_valid = 1'b1;
        bus.wdata = 8'h3C;
        step();
        bus.wdata_valid = 1'b0;
        step();
        step();
        step();
        check("abort_still_shifting", bus.scan_en, 1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", 32'(outs()), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("abort_no_rdata", cnt_rv - b_rv, 0);
        check("abort_idle", {bus.cmd_ready, bus.busy, bus.wdata_ready}, 3'b100);

        // Randomized shifts: SI must replay the write bits, RDATA must pack the SO bits.
        so_mode = 2;
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 40);
            bp = $urandom_range(0, 3);
            nw = (n + 7) / 8;
            wq.delete();
            for (int w = 0; w < nw; w++) wq.push_back(8'($urandom));
            b_scan = cnt_scan;
            sbase = si_q.size();
            run_shift(n, bp);
            check("rnd_scan_cycles", cnt_scan - b_scan, n);
            check("rnd_words", rq.size(), nw);
            if (rq.size() == nw && si_q.size() >= sbase + n) begin
                for (int w = 0; w < nw; w++) begin
                    nb = (n - 8 * w > 8) ? 8 : n - 8 * w;
                    exp = 8'h00;
                    for (int b = 0; b < nb; b++) exp[b] = so_q[sbase + 8 * w + b];
                    check("rnd_rdata", rq[w], exp);
                    check("rnd_last", lq[w], (w == nw - 1) ? 1 : 0);
                end
                for (int i = 0; i < n; i++) check("rnd_si_bit", si_q[sbase + i], wq[i / 8][i % 8]);
            end
        end

        check("scan_si_quiet_outside_shift", cnt_si_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/difetto_bsr_driver.md
Name: difetto_bsr_driver

Overview:
- Host-side controller that drives a serial boundary-scan chain built from the design's input/output boundary-scan cells.
- Accepts CAPTURE, UPDATE and SHIFT commands over a valid/ready interface.
- For SHIFT, it serialises host write words onto the chain and deserialises the chain's serial output into read words.
- Sits between the test access logic (host) and the scan-chain head/tail pins.

Parameters:
WORD_W, 32, width of host write/read data words (>=1)
LEN_W, 16, width of the SHIFT bit-length field

Ports:
CLK  input  1  clock, all logic on rising edge
RST_N  input  1  asynchronous active-low reset
CMD_VALID  input  1  command valid
CMD_READY  output  1  command ready (high only in IDLE)
CMD_OP  input  2  00 CAPTURE, 01 UPDATE, 10 SHIFT, 11 reserved
CMD_LEN  input  LEN_W  SHIFT length in bits
WDATA_VALID  input  1  write word valid
WDATA_READY  output  1  write word ready
WDATA  input  WORD_W  bits to shift in, LSB first
RDATA_VALID  output  1  read word valid
RDATA_READY  input  1  read word ready
RDATA  output  WORD_W  bits shifted out, LSB first
RDATA_LAST  output  1  marks final read word of a SHIFT
SCAN_EN  output  1  chain shift enable
SCAN_SI  output  1  serial data into chain head
SCAN_SO  input  1  serial data from chain tail
CAPTURE_EN  output  1  one-cycle capture strobe to chain
UPDATE_EN  output  1  one-cycle update strobe to chain
BUSY  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, RST_N low):
  - State goes to IDLE; shift/read registers and bit counters are cleared.
  - All outputs are 0, including CMD_READY.
  - CMD_READY rises on the first CLK edge after reset is released.
  - A reset mid-SHIFT aborts the operation. No RDATA is produced and partial data is discarded.
- States: IDLE, CAP, UPD, LOAD, SHIFT, EMIT.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID&&CMD_READY: CMD_LEN is latched into the remaining-bit counter.
  - Next state by op: CAPTURE -> CAP; UPDATE -> UPD; SHIFT with LEN>0 -> LOAD; SHIFT with LEN==0 or op 11 -> stay in IDLE (no-op, no strobes, no words).
- CAP: CAPTURE_EN=1 for exactly one cycle, then IDLE.
- UPD: UPDATE_EN=1 for exactly one cycle, then IDLE.
  - A command accepted at edge t gives its strobe in cycle t+1, and CMD_READY is high again at t+2.
- LOAD:
  - WDATA_READY=1.
  - On a WDATA handshake: WDATA loads the shift register, the word-bit count is set to min(WORD_W, remaining), the read register is cleared, and the state goes to SHIFT.
- SHIFT, one bit per cycle:
  - SCAN_EN=1 and SCAN_SI = shift register bit 0.
  - SCAN_SO is sampled at the same edge into read bit k, where k = bit index within the word.
  - Shift register shifts right; remaining count decrements.
  - After the word's last bit, go to EMIT.
  - SCAN_EN is never high outside SHIFT. SCAN_SI=0 outside SHIFT.
- EMIT:
  - RDATA_VALID=1 and RDATA = read register. Bits at or above the word-bit count are 0.
  - RDATA_LAST=1 when remaining==0.
  - RDATA, RDATA_VALID and RDATA_LAST stay stable until RDATA_READY.
  - On handshake: go to LOAD if remaining>0, else IDLE.
- Latency: a WDATA accepted at edge t gives the first SCAN_EN in cycle t+1. An n-bit word gives RDATA_VALID in cycle t+n+1.
- No WDATA or RDATA handshakes occur outside LOAD or EMIT; the READY/VALID outputs are 0 there.
- Word count: a SHIFT of N bits uses exactly ceil(N/WORD_W) write and read words. The final word is partial when N is not a multiple of WORD_W; its unused WDATA upper bits are ignored.
- Maximum N = 2^LEN_W - 1. No wrap of the counter; it stops at 0.
- A command presented while BUSY is not accepted; it waits for CMD_READY.

Test Plan:
- Reset then idle, WORD_W=8: RST_N low -> all outputs 0; RST_N high -> CMD_READY=1 after one edge, BUSY=0.
- CAPTURE then UPDATE back-to-back:
  - Expected: CAPTURE_EN high exactly 1 cycle, then CMD_READY, then UPDATE_EN 1 cycle.
  - Expected: SCAN_EN never high.
- SHIFT N=8, WDATA=0xA5, SCAN_SO looped from SCAN_SI through a 3-bit delay preloaded 0b101:
  - SCAN_SI sequence is 1,0,1,0,0,1,0,1.
  - RDATA=0x2D, RDATA_LAST=1.
  - 8 SCAN_EN cycles total.
- SHIFT N=12, WDATA=0xFF then 0x0F, SCAN_SO=1:
  - Expected words: RDATA=0xFF (LAST=0), then RDATA=0x0F (LAST=1).
  - Expected: 12 SCAN_EN cycles total.
- Backpressure: hold RDATA_READY=0 for 5 cycles in EMIT -> RDATA stable, SCAN_EN=0, no WDATA_READY; resumes on release.
- No-op and abort cases:
  - SHIFT N=0 -> no strobes, no words, CMD_READY again next cycle.
  - RST_N pulsed after 3 shifted bits of N=8 -> no RDATA_VALID, IDLE after release.
